// File: rtl/mips_pkg.sv
// Shared widths and loader state encoding for the MIPS instruction-memory boot loader.
package mips_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned WORD_SHIFT = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StLoad,
        StCheck,
        StFlush,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: three bytes are held, the fourth completes the word
// combinationally so the consumer can register it on the same edge.
module byte_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_en,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic [1:0]               r_cnt;

    assign word       = {r_shift, byte_in};
    assign word_valid = byte_en && (r_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (byte_en) begin
            r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], byte_in};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte frame, writes instruction words into imem,
// then releases the core. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [WORD_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_WORDS);

    loader_state_e     r_state;
    logic [BYTE_W-1:0] r_len_hi;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W:0]   r_words;
    logic              r_we;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_run;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_csum;
`endif

    logic              w_rx_ready;
    logic              w_xfer;
    logic              w_start_ok;
    logic              w_byte_en;
    logic              w_word_valid;
    logic              w_last_word;
    logic [WORD_W-1:0] w_word;
    logic [LEN_W-1:0]  w_len;

    assign w_rx_ready  = r_state inside {StLenHi, StLenLo, StLoad, StCheck};
    assign w_xfer      = rx_valid && w_rx_ready;
    assign w_start_ok  = start && (r_state inside {StIdle, StDone, StErr});
    assign w_byte_en   = w_xfer && (r_state == StLoad);
    assign w_len       = {r_len_hi, rx_data};
    assign w_last_word = (LEN_W'(r_words + 1'b1) == r_len);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_start_ok),
        .byte_in    (rx_data),
        .byte_en    (w_byte_en),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_len_hi <= '0;
            r_len    <= '0;
            r_words  <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_run    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        r_state <= StLenHi;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_run   <= 1'b0;
                        r_words <= '0;
                        r_len   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                StLenHi: begin
                    if (w_xfer) begin
                        r_len_hi <= rx_data;
                        r_state  <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if (w_len == '0 || w_len > MaxLen) begin
                            r_state <= StErr;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b0 | 1'b1;
                        end else begin
                            r_state <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ rx_data;
`endif
                        if (w_word_valid) begin
                            r_we    <= 1'b1;
                            r_wdata <= w_word;
                            r_addr  <= WORD_W'(r_words) << WORD_SHIFT;
                            r_words <= r_words + 1'b1;
                            // The write cycle doubles as FLUSH (or CHECK) so cpu_run follows it.
                            if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                r_state <= StCheck;
`else
                                r_state <= StFlush;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StCheck: begin
                    if (w_xfer) begin
                        if (rx_data == r_csum) begin
                            r_state <= StFlush;
                        end else begin
                            r_state <= StErr;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                StFlush: begin
                    r_state <= StDone;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_run   <= 1'b1;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready     = w_rx_ready;
    assign im_we        = r_we;
    assign im_addr      = r_addr;
    assign im_wdata     = r_wdata;
    assign cpu_run      = r_run;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frames are parsed by a byte-level reference model
// and every imem write, plus the end-of-load status, is compared against it.
module tb_imem_boot_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              im_we;
    logic [31:0]       im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_run;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [ADDR_W:0] cnt;
    } wr_t;

    int         n_checks = 0;
    int         n_fail = 0;
    wr_t        exp_q[$];
    wr_t        log_q[$];
    logic [7:0] frame[$];
    bit         exp_ok;
    int         exp_words;
    bit         chk_en = 1'b0;
    logic       prev_we = 1'b0;
    logic       prev_run = 1'b0;
    wr_t        cur_e;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endfunction

    // Reference model: parse the frame byte list into expected writes and final status.
    task automatic build_model();
        int         n;
        logic [7:0] x;
        exp_q.delete();
        n = int'({frame[0], frame[1]});
        exp_ok = (n >= 1 && n <= MAX_WORDS);
        exp_words = 0;
        if (!exp_ok) return;
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            wr_t e;
            e.addr = 32'(w * 4);
            e.data = {frame[2 + 4*w], frame[3 + 4*w], frame[4 + 4*w], frame[5 + 4*w]};
            e.cnt  = (ADDR_W + 1)'(w + 1);
            exp_q.push_back(e);
            for (int b = 0; b < 4; b++) x = x ^ frame[2 + 4*w + b];
        end
        exp_words = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (frame[2 + 4*n] != x) exp_ok = 1'b0;
`endif
    endtask

    function automatic void add_csum(bit corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < frame.size(); i++) x = x ^ frame[i];
        frame.push_back(corrupt ? (x ^ 8'h01) : x);
`endif
    endfunction

    function automatic void make_frame(int n, bit corrupt);
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        if (n >= 1 && n <= MAX_WORDS) begin
            for (int i = 0; i < 4*n; i++) frame.push_back(8'($urandom));
            add_csum(corrupt);
        end
    endfunction

    // Per-cycle scoreboard on the write port and run/done relationship.
    always @(negedge clk) begin
        if (chk_en) begin
            if (im_we) begin
                cur_e.addr = im_addr;
                cur_e.data = im_wdata;
                cur_e.cnt  = words_loaded;
                log_q.push_back(cur_e);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none required",
                             im_addr, im_wdata);
                end else begin
                    cur_e = exp_q.pop_front();
                    check("write_addr", im_addr, cur_e.addr);
                    check("write_data", im_wdata, cur_e.data);
                    check("write_count", words_loaded, cur_e.cnt);
                end
            end
            if (cpu_run && !prev_run) check("run_one_after_last_we", prev_we, 1'b1);
            check("run_eq_done", cpu_run, done);
            prev_we  <= im_we;
            prev_run <= cpu_run;
        end
    end

    task automatic do_start();
        @(negedge clk);
        rx_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_status", {busy, done, err, cpu_run, words_loaded}, 13'h1000);
    endtask

    // mode 0: back-to-back, 1: valid toggles every other cycle, 2: random valid.
    task automatic send_bytes(int count, int mode, bit noise, bit check_end);
        int i = 0;
        int cyc = 0;
        bit v;
        bit toggle = 1'b0;
        while (i < count) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc > 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: sent %0d of %0d bytes", i, count);
                rx_valid = 1'b0;
                return;
            end
            case (mode)
                0: v = 1'b1;
                1: begin v = toggle; toggle = !toggle; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            rx_valid = v;
            rx_data  = v ? frame[i] : 8'($urandom);
            if (noise && $urandom_range(0, 9) == 0) start = 1'b1;
            if (v && rx_ready) i++;
            cyc++;
        end
        @(negedge clk);
        start = 1'b0;
        if (check_end) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            check("rx_ready_after_frame", rx_ready, 1'b0);
        end else begin
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done || err) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("end_within_budget", k < 20, 1'b1);
        check("done", done, exp_ok);
        check("err", err, !exp_ok);
        check("cpu_run", cpu_run, exp_ok);
        check("busy_end", busy, 1'b0);
        check("words_loaded", words_loaded, exp_words);
        check("writes_left", exp_q.size(), 0);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(int mode, bit noise);
        build_model();
        do_start();
        send_bytes(frame.size(), mode, noise, 1'b1);
        wait_end();
    endtask

    task automatic basic_frame();
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        add_csum(1'b0);
    endtask

    task automatic check_basic_log(string tag);
        check({tag, "_nwrites"}, log_q.size(), 2);
        if (log_q.size() == 2) begin
            check({tag, "_addr0"}, log_q[0].addr, 32'h0);
            check({tag, "_data0"}, log_q[0].data, 32'h20080005);
            check({tag, "_addr1"}, log_q[1].addr, 32'h4);
            check({tag, "_data1"}, log_q[1].data, 32'h8C090004);
        end
        check({tag, "_words"}, words_loaded, 2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", {rx_ready, im_we, cpu_run, busy, done, err, words_loaded}, 0);
        check("reset_addr_data", {im_addr, im_wdata}, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Idle with a valid source and no start.
        rx_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rx_data = 8'($urandom);
            @(negedge clk);
            check("idle_rx_ready", rx_ready, 1'b0);
            check("idle_outs", {im_we, cpu_run, busy, done, err, words_loaded}, 0);
            check("idle_addr_data", {im_addr, im_wdata}, 0);
        end
        rx_valid = 1'b0;

        log_q.delete();
        basic_frame();
        run_frame(0, 1'b0);
        check_basic_log("basic");

        log_q.delete();
        basic_frame();
        run_frame(1, 1'b0);
        check_basic_log("throttled");

        frame = '{8'h00, 8'h00};
        run_frame(0, 1'b0);
        check("len0_err", {err, cpu_run}, 2'b10);
        frame = '{8'h01, 8'h01};
        run_frame(0, 1'b0);
        check("len257_err", {err, cpu_run}, 2'b10);

        // Reset after six data bytes, then a fresh one-word load.
        log_q.delete();
        make_frame(2, 1'b0);
        build_model();
        do_start();
        send_bytes(8, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("midreset_outs", {rx_ready, im_we, cpu_run, busy, done, err, words_loaded}, 0);
        check("midreset_writes", log_q.size(), 1);
        rst_n = 1'b1;
        log_q.delete();
        make_frame(1, 1'b0);
        run_frame(0, 1'b0);
        check("after_reset_nwrites", log_q.size(), 1);
        if (log_q.size() == 1) check("after_reset_addr", log_q[0].addr, 32'h0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_frame(0, 1'b0);
        check("csum_good_done", {done, err}, 2'b10);
        frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        run_frame(0, 1'b0);
        check("csum_bad_err", {done, err, cpu_run}, 3'b010);
`endif

        make_frame(MAX_WORDS, 1'b0);
        run_frame(0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) make_frame(0, 1'b0);
            else if (kind == 1) make_frame($urandom_range(MAX_WORDS + 1, 65535), 1'b0);
            else make_frame($urandom_range(1, 6), ($urandom_range(0, 4) == 0));
            run_frame($urandom_range(0, 2), 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
